result_drain: RTL and testbench

//   Output stage directly downstream of the MulAdd processor array top level, in the clk_pe domain.

---
 rtl/result_drain.sv | 106 ++++++++++
 tb/tb_result_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Result drain: captures PE-array result beats into a fall-through FIFO, tags frame-final results,
// and re-emits them on a valid/ready stream. Optional macro RESULT_DRAIN_RELU_EN clamps negatives to 0.
module result_drain #(
    parameter int WIDTH_MDATA = 32,
    parameter int SIZE_MAT    = 16,
    parameter int DEPTH       = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                   clk_pe,
    input  logic                   rst,
    input  logic                   result_valid_i,
    input  logic [WIDTH_MDATA-1:0] result_payload_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH_MDATA-1:0] out_payload_o,
    output logic                   out_last_o,
    output logic [AW:0]            level_o,
    output logic                   overflow_o
);

    localparam int FRAME_LEN = SIZE_MAT * SIZE_MAT;
    localparam int FW        = $clog2(FRAME_LEN);
    localparam logic [FW-1:0] FRAME_END = FW'(FRAME_LEN - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH_MDATA:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            level;
    logic [FW-1:0]          frame_cnt;
    logic                   overflow;

    logic                   full;
    logic                   not_empty;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   last_bit;
    logic [WIDTH_MDATA-1:0] wr_data;
    logic [WIDTH_MDATA:0]   head;

    assign full      = (level == FULL_LEVEL);
    assign not_empty = (level != '0);
    assign pop       = not_empty & out_ready_i;
    assign push      = result_valid_i & (~full | pop);
    assign drop      = result_valid_i & full & ~pop;
    assign last_bit  = (frame_cnt == FRAME_END);

`ifdef RESULT_DRAIN_RELU_EN
    assign wr_data = result_payload_i[WIDTH_MDATA-1] ? '0 : result_payload_i;
`else
    assign wr_data = result_payload_i;
`endif

    // Storage is deliberately not reset; only pointers and level define validity.
    always_ff @(posedge clk_pe) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {last_bit, wr_data};
        end
    end

    always_ff @(posedge clk_pe) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Frame counter advances on every offered beat, including dropped ones, to keep alignment.
    always_ff @(posedge clk_pe) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (result_valid_i) begin
            frame_cnt <= last_bit ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pe) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr];
    assign out_valid_o   = not_empty;
    assign out_payload_o = not_empty ? head[WIDTH_MDATA-1:0] : '0;
    assign out_last_o    = not_empty ? head[WIDTH_MDATA] : 1'b0;
    assign level_o       = level;
    assign overflow_o    = overflow;

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain: ordering, framing, overflow, full push+pop, reset and clamp.
module tb_result_drain;

    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic          clk_pe = 1'b0;
    logic          rst;
    logic          result_valid_i;
    logic [W-1:0]  result_payload_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_payload_o;
    logic          out_last_o;
    logic [4:0]    level_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;

    result_drain #(.WIDTH_MDATA(W), .SIZE_MAT(16), .DEPTH(DEPTH)) dut (
        .clk_pe           (clk_pe),
        .rst              (rst),
        .result_valid_i   (result_valid_i),
        .result_payload_i (result_payload_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_payload_o    (out_payload_o),
        .out_last_o       (out_last_o),
        .level_o          (level_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_pe = ~clk_pe;

    // Advance one edge and settle inputs/outputs just after it.
    task automatic tick();
        @(posedge clk_pe);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        result_valid_i = 1'b0;
        result_payload_i = '0;
        out_ready_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid_o !== 1'b0 || level_o !== 5'd0 || overflow_o !== 1'b0 ||
            out_payload_o !== '0 || out_last_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b lvl=%0d ovf=%b pl=%h last=%b want 0 0 0 0 0",
                     out_valid_o, level_o, overflow_o, out_payload_o, out_last_o);
        end
    endtask

    task automatic test_basic_order();
        logic [W-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            result_valid_i = 1'b1;
            result_payload_i = vals[i];
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_payload_o !== vals[i] || level_o !== 5'd1) begin
                errors++;
                $display("[TB] FAIL basic_order[%0d] got v=%b pl=%h lvl=%0d want 1 %h 1",
                         i, out_valid_o, out_payload_o, level_o, vals[i]);
            end
        end
        result_valid_i = 1'b0;
        tick();
        checks++;
        if (level_o !== 5'd0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_drain got lvl=%0d v=%b want 0 0", level_o, out_valid_o);
        end
    endtask

    task automatic test_framing();
        int bad = 0;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 512; i++) begin
            result_valid_i = 1'b1;
            result_payload_i = W'(i);
            tick();
            checks++;
            if (out_payload_o !== W'(i) || out_last_o !== ((i % 256) == 255)) begin
                errors++;
                if (bad++ < 8)
                    $display("[TB] FAIL framing[%0d] got pl=%h last=%b want %h %b",
                             i, out_payload_o, out_last_o, W'(i), ((i % 256) == 255));
            end
        end
        result_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            result_valid_i = 1'b1;
            result_payload_i = W'(i);
            tick();
            if (i == 15) begin
                checks++;
                if (level_o !== 5'd16 || overflow_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_full got lvl=%0d ovf=%b want 16 0", level_o, overflow_o);
                end
            end
        end
        result_valid_i = 1'b0;
        checks++;
        if (level_o !== 5'd16 || overflow_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set got lvl=%0d ovf=%b want 16 1", level_o, overflow_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_payload_o !== W'(i)) begin
                errors++;
                $display("[TB] FAIL ovf_drain[%0d] got v=%b pl=%h want 1 %h",
                         i, out_valid_o, out_payload_o, W'(i));
            end
            tick();
        end
        checks++;
        if (level_o !== 5'd0 || overflow_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky got lvl=%0d ovf=%b want 0 1", level_o, overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            result_valid_i = 1'b1;
            result_payload_i = 32'h100 + W'(i);
            tick();
        end
        result_payload_i = 32'hABC;
        out_ready_i = 1'b1;
        tick();
        result_valid_i = 1'b0;
        checks++;
        if (level_o !== 5'd16 || overflow_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_pushpop got lvl=%0d ovf=%b want 16 0", level_o, overflow_o);
        end
        for (int i = 1; i <= 16; i++) begin
            logic [W-1:0] exp;
            exp = (i == 16) ? 32'hABC : 32'h100 + W'(i);
            checks++;
            if (out_valid_o !== 1'b1 || out_payload_o !== exp) begin
                errors++;
                $display("[TB] FAIL full_order[%0d] got v=%b pl=%h want 1 %h",
                         i, out_valid_o, out_payload_o, exp);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            out_ready_i = (i < 95);
            result_valid_i = 1'b1;
            result_payload_i = W'(i);
            if (i == 95) begin
                result_valid_i = 1'b0;
                out_ready_i = 1'b1;
                tick();
                out_ready_i = 1'b0;
                result_valid_i = 1'b1;
            end
            tick();
        end
        result_valid_i = 1'b0;
        checks++;
        if (level_o !== 5'd5) begin
            errors++;
            $display("[TB] FAIL midrst_pre got lvl=%0d want 5", level_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || level_o !== 5'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_clear got v=%b lvl=%0d ovf=%b want 0 0 0",
                     out_valid_o, level_o, overflow_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            result_valid_i = 1'b1;
            result_payload_i = 32'h5000 + W'(i);
            tick();
            checks++;
            if (out_last_o !== (i == 255) || out_payload_o !== 32'h5000 + W'(i)) begin
                errors++;
                if (bad++ < 8)
                    $display("[TB] FAIL midrst_frame[%0d] got last=%b pl=%h want %b %h",
                             i, out_last_o, out_payload_o, (i == 255), 32'h5000 + W'(i));
            end
        end
        result_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        logic [W-1:0] exp0;
`ifdef RESULT_DRAIN_RELU_EN
        exp0 = 32'h0000_0000;
`else
        exp0 = 32'hFFFF_FFF6;
`endif
        do_reset();
        out_ready_i = 1'b0;
        result_valid_i = 1'b1;
        result_payload_i = 32'hFFFF_FFF6;
        tick();
        result_payload_i = 32'h0000_0007;
        tick();
        result_valid_i = 1'b0;
        checks++;
        if (out_payload_o !== exp0) begin
            errors++;
            $display("[TB] FAIL clamp_neg got %h want %h", out_payload_o, exp0);
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_payload_o !== 32'h7 || level_o !== 5'd1) begin
            errors++;
            $display("[TB] FAIL clamp_pos got pl=%h lvl=%0d want 00000007 1", out_payload_o, level_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_framing();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
